// File: rtl/odd_pipe_pkg.sv
// Shared types and constants for the odd-pipe result select / writeback block.
package odd_pipe_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 8;

  // Source-unit tag carried with every staged result
  typedef enum logic [1:0] {
    UNIT_NONE = 2'd0,
    UNIT_PERM = 2'd1,
    UNIT_LS   = 2'd2,
    UNIT_BR   = 2'd3
  } unit_e;

  // One staging slot; bit 0 of rt/data is the MSB (big-endian numbering)
  typedef struct packed {
    logic               valid;
    unit_e              unit;
    logic [0:ADDR_W-1]  rt;
    logic [0:DATA_W-1]  data;
  } stage_t;

  localparam stage_t STAGE_RESET = '{
    valid: 1'b0,
    unit:  UNIT_NONE,
    rt:    {ADDR_W{1'b0}},
    data:  {DATA_W{1'b0}}
  };

  // True when two or more of the three result valids are high together
  function automatic logic multi_valid(input logic p, input logic l, input logic b);
    return (p & l) | (p & b) | (l & b);
  endfunction

endpackage

// File: rtl/odd_result_select_if.sv
// Result-select bus: unit results in, writeback and forwarding taps out.
// Optional coll_cnt exists only when ODD_SEL_COLLISION_CNT_EN is defined.
interface odd_result_select_if
  import odd_pipe_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic                      perm_valid;
  logic [0:DATA_W-1]         perm_data;
  logic [0:ADDR_W-1]         perm_rt;
  logic                      ls_valid;
  logic [0:DATA_W-1]         ls_data;
  logic [0:ADDR_W-1]         ls_rt;
  logic                      br_valid;
  logic [0:DATA_W-1]         br_data;
  logic [0:ADDR_W-1]         br_rt;

  logic                      wb_we;
  logic [0:DATA_W-1]         wb_data;
  logic [0:ADDR_W-1]         wb_rt;
  logic [1:0]                wb_unit;
  logic [0:DEPTH-1]          fwd_valid;
  logic [0:DEPTH*ADDR_W-1]   fwd_rt;
  logic [0:DEPTH*DATA_W-1]   fwd_data;
  logic                      collision_err;
`ifdef ODD_SEL_COLLISION_CNT_EN
  logic [0:CNT_W-1]          coll_cnt;
`endif

  modport master (
    output perm_valid, perm_data, perm_rt,
    output ls_valid, ls_data, ls_rt,
    output br_valid, br_data, br_rt,
    input  wb_we, wb_data, wb_rt, wb_unit,
    input  fwd_valid, fwd_rt, fwd_data,
    input  collision_err
`ifdef ODD_SEL_COLLISION_CNT_EN
    , input coll_cnt
`endif
  );

  modport slave (
    input  perm_valid, perm_data, perm_rt,
    input  ls_valid, ls_data, ls_rt,
    input  br_valid, br_data, br_rt,
    output wb_we, wb_data, wb_rt, wb_unit,
    output fwd_valid, fwd_rt, fwd_data,
    output collision_err
`ifdef ODD_SEL_COLLISION_CNT_EN
    , output coll_cnt
`endif
  );

endinterface

// File: rtl/odd_pipe_stage.sv
// One staging register of the odd-pipe writeback pipe: async clear,
// synchronous flush that drops the valid (payload kept, tag forced to none).
module odd_pipe_stage
  import odd_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  stage_t in_s,
  output stage_t stage_q
);

  stage_t stage_d;

  // Next slot contents: take the upstream entry unless the pipe is flushed
  always_comb begin
    stage_d = in_s;
    if (flush) begin
      stage_d       = stage_q;
      stage_d.valid = 1'b0;
      stage_d.unit  = UNIT_NONE;
    end else begin
      stage_d = in_s;
    end
  end

  // Slot register with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= STAGE_RESET;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/odd_result_select.sv
// Odd-pipe result select: fixed-priority pick (perm > ls > br), DEPTH-stage
// staging pipe to the register-file write port, forwarding taps, sticky
// collision flag. Optional saturating collision counter: ODD_SEL_COLLISION_CNT_EN.
module odd_result_select
  import odd_pipe_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                unit_reset,
  odd_result_select_if.slave  bus
);

  stage_t sel_s;
  stage_t stage_in_s [DEPTH];
  stage_t stage_q    [DEPTH];
  logic   collision_s;
  logic   collision_err_d;
  logic   collision_err_q;

  assign collision_s = multi_valid(bus.perm_valid, bus.ls_valid, bus.br_valid);

  // Priority select; with nothing valid the head slot keeps its payload
  always_comb begin
    sel_s       = stage_q[0];
    sel_s.valid = 1'b0;
    sel_s.unit  = UNIT_NONE;
    if (bus.perm_valid) begin
      sel_s = '{valid: 1'b1, unit: UNIT_PERM, rt: bus.perm_rt, data: bus.perm_data};
    end else if (bus.ls_valid) begin
      sel_s = '{valid: 1'b1, unit: UNIT_LS, rt: bus.ls_rt, data: bus.ls_data};
    end else if (bus.br_valid) begin
      sel_s = '{valid: 1'b1, unit: UNIT_BR, rt: bus.br_rt, data: bus.br_data};
    end else begin
      sel_s.valid = 1'b0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in_s[i] = sel_s;
    end else begin : g_body
      assign stage_in_s[i] = stage_q[i-1];
    end

    odd_pipe_stage u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (unit_reset),
      .in_s    (stage_in_s[i]),
      .stage_q (stage_q[i])
    );

    assign bus.fwd_valid[i]                  = stage_q[i].valid;
    assign bus.fwd_rt[i*ADDR_W +: ADDR_W]    = stage_q[i].rt;
    assign bus.fwd_data[i*DATA_W +: DATA_W]  = stage_q[i].data;
  end

  // Writeback port is the last slot; its tag is already none when invalid
  assign bus.wb_we   = stage_q[DEPTH-1].valid;
  assign bus.wb_rt   = stage_q[DEPTH-1].rt;
  assign bus.wb_data = stage_q[DEPTH-1].data;
  assign bus.wb_unit = stage_q[DEPTH-1].unit;

  // Sticky collision flag: flush clears and wins over a new collision
  always_comb begin
    collision_err_d = collision_err_q;
    if (unit_reset) begin
      collision_err_d = 1'b0;
    end else if (collision_s) begin
      collision_err_d = 1'b1;
    end else begin
      collision_err_d = collision_err_q;
    end
  end

  // Collision flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collision_err_q <= 1'b0;
    end else begin
      collision_err_q <= collision_err_d;
    end
  end

  assign bus.collision_err = collision_err_q;

`ifdef ODD_SEL_COLLISION_CNT_EN
  logic [0:CNT_W-1] coll_cnt_d;
  logic [0:CNT_W-1] coll_cnt_q;

  // Saturating collision-cycle count, one per cycle however many collided
  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (unit_reset) begin
      coll_cnt_d = 8'd0;
    end else if (collision_s && (coll_cnt_q != 8'd255)) begin
      coll_cnt_d = coll_cnt_q + 8'd1;
    end else begin
      coll_cnt_d = coll_cnt_q;
    end
  end

  // Collision counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_cnt_q <= 8'd0;
    end else begin
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign bus.coll_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_odd_result_select.sv
// Directed bench for odd_result_select (DEPTH = 4); expected values hand-derived.
module tb_odd_result_select;
  import odd_pipe_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic unit_reset;
  int   total = 0;
  int   bad   = 0;

  odd_result_select_if #(.DEPTH(DEPTH)) bus ();

  odd_result_select #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .unit_reset (unit_reset),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.perm_valid = 1'b0;
    bus.ls_valid   = 1'b0;
    bus.br_valid   = 1'b0;
  endtask

  task automatic put_perm(input logic [6:0] rt, input logic [127:0] d);
    bus.perm_valid = 1'b1; bus.perm_rt = rt; bus.perm_data = d;
  endtask

  task automatic put_ls(input logic [6:0] rt, input logic [127:0] d);
    bus.ls_valid = 1'b1; bus.ls_rt = rt; bus.ls_data = d;
  endtask

  task automatic put_br(input logic [6:0] rt, input logic [127:0] d);
    bus.br_valid = 1'b1; bus.br_rt = rt; bus.br_data = d;
  endtask

  initial begin
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    reset      = 1'b0;
    unit_reset = 1'b0;
    idle();
    bus.perm_rt = 7'd0; bus.perm_data = 128'd0;
    bus.ls_rt   = 7'd0; bus.ls_data   = 128'd0;
    bus.br_rt   = 7'd0; bus.br_data   = 128'd0;

    // Reset state
    #1;
    check("rst_fwd_valid", bus.fwd_valid, 4'b0000);
    check("rst_wb_we", bus.wb_we, 1'b0);
    check("rst_wb_unit", bus.wb_unit, 2'd0);
    check("rst_wb_rt", bus.wb_rt, 7'd0);
    check("rst_wb_data", bus.wb_data, 128'd0);
    check("rst_coll_err", bus.collision_err, 1'b0);
`ifdef ODD_SEL_COLLISION_CNT_EN
    check("rst_coll_cnt", bus.coll_cnt, 8'd0);
`endif

    // Single perm result: first capture on first edge after release
    #2;
    reset = 1'b1;
    put_perm(7'd5, a5);
    tick();
    idle();
    check("single_s0_valid", bus.fwd_valid, 4'b1000);
    check("single_s0_rt", bus.fwd_rt[0:6], 7'd5);
    check("single_s0_data", bus.fwd_data[0:127], a5);
    check("single_wb_early", bus.wb_we, 1'b0);
    tick();
    check("single_s1_valid", bus.fwd_valid, 4'b0100);
    tick();
    check("single_s2_valid", bus.fwd_valid, 4'b0010);
    tick();
    check("single_wb_we", bus.wb_we, 1'b1);
    check("single_wb_rt", bus.wb_rt, 7'd5);
    check("single_wb_unit", bus.wb_unit, 2'd1);
    check("single_wb_data", bus.wb_data, a5);
    tick();
    check("single_wb_gone", bus.wb_we, 1'b0);
    check("single_wb_unit0", bus.wb_unit, 2'd0);

    // Back-to-back perm, ls, br
    put_perm(7'd1, 128'h1111);
    tick();
    idle();
    put_ls(7'd2, 128'h2222);
    tick();
    idle();
    put_br(7'd3, 128'h3333);
    tick();
    idle();
    check("b2b_fwd_valid", bus.fwd_valid, 4'b1110);
    check("b2b_fwd_rt", bus.fwd_rt[0:20], {7'd3, 7'd2, 7'd1});
    check("b2b_fwd_d1", bus.fwd_data[128:255], 128'h2222);
    tick();
    check("b2b_wb1_rt", bus.wb_rt, 7'd1);
    check("b2b_wb1_unit", bus.wb_unit, 2'd1);
    check("b2b_wb1_data", bus.wb_data, 128'h1111);
    tick();
    check("b2b_wb2_we", bus.wb_we, 1'b1);
    check("b2b_wb2_rt", bus.wb_rt, 7'd2);
    check("b2b_wb2_unit", bus.wb_unit, 2'd2);
    tick();
    check("b2b_wb3_we", bus.wb_we, 1'b1);
    check("b2b_wb3_rt", bus.wb_rt, 7'd3);
    check("b2b_wb3_unit", bus.wb_unit, 2'd3);
    check("b2b_wb3_data", bus.wb_data, 128'h3333);
    tick();
    check("b2b_wb_end", bus.wb_we, 1'b0);
    check("b2b_no_coll", bus.collision_err, 1'b0);

    // Collision: perm beats ls
    put_perm(7'd4, 128'h4444);
    put_ls(7'd9, 128'h9999);
    tick();
    idle();
    check("coll_err_set", bus.collision_err, 1'b1);
    check("coll_s0_valid", bus.fwd_valid, 4'b1000);
    check("coll_s0_rt", bus.fwd_rt[0:6], 7'd4);
    check("coll_s0_data", bus.fwd_data[0:127], 128'h4444);
`ifdef ODD_SEL_COLLISION_CNT_EN
    check("coll_cnt_one", bus.coll_cnt, 8'd1);
`endif
    tick();
    tick();
    tick();
    check("coll_wb_we", bus.wb_we, 1'b1);
    check("coll_wb_rt", bus.wb_rt, 7'd4);
    check("coll_wb_unit", bus.wb_unit, 2'd1);
    tick();
    check("coll_ls_dropped", bus.wb_we, 1'b0);
    check("coll_err_sticky", bus.collision_err, 1'b1);

    // Flush with three stages valid and br presented at the flush edge
    put_perm(7'd10, 128'hA);
    tick();
    put_perm(7'd11, 128'hB);
    tick();
    put_perm(7'd12, 128'hC);
    tick();
    idle();
    check("flush_pre_valid", bus.fwd_valid, 4'b1110);
    put_br(7'd13, 128'hD);
    unit_reset = 1'b1;
    tick();
    unit_reset = 1'b0;
    idle();
    check("flush_fwd_valid", bus.fwd_valid, 4'b0000);
    check("flush_coll_clr", bus.collision_err, 1'b0);
`ifdef ODD_SEL_COLLISION_CNT_EN
    check("flush_cnt_clr", bus.coll_cnt, 8'd0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      check("flush_no_wb", bus.wb_we, 1'b0);
      tick();
    end
    check("flush_fwd_empty", bus.fwd_valid, 4'b0000);

    // Asynchronous reset with the pipe full and collision flag set
    put_perm(7'd20, 128'h20);
    tick();
    put_perm(7'd21, 128'h21);
    tick();
    put_perm(7'd22, 128'h22);
    tick();
    put_perm(7'd23, 128'h23);
    put_br(7'd40, 128'h40);
    tick();
    idle();
    check("full_fwd_valid", bus.fwd_valid, 4'b1111);
    check("full_wb_rt", bus.wb_rt, 7'd20);
    check("full_coll_err", bus.collision_err, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_fwd_valid", bus.fwd_valid, 4'b0000);
    check("arst_wb_we", bus.wb_we, 1'b0);
    check("arst_wb_unit", bus.wb_unit, 2'd0);
    check("arst_wb_data", bus.wb_data, 128'd0);
    check("arst_coll_err", bus.collision_err, 1'b0);
    #1;
    reset = 1'b1;
    put_ls(7'd30, 128'h30);
    tick();
    idle();
    check("rel_s0_valid", bus.fwd_valid, 4'b1000);
    check("rel_s0_rt", bus.fwd_rt[0:6], 7'd30);

`ifdef ODD_SEL_COLLISION_CNT_EN
    // Counter saturation over 300 collision cycles
    for (int i = 0; i < 300; i++) begin
      put_perm(7'd1, 128'h1);
      put_ls(7'd2, 128'h2);
      put_br(7'd3, 128'h3);
      tick();
    end
    idle();
    check("sat_coll_cnt", bus.coll_cnt, 8'd255);
    tick();
    check("sat_hold", bus.coll_cnt, 8'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odd_result_select.md
# odd_result_select

Odd-pipe result select and writeback pipeline. Accepts completed results from the three odd-pipe execution units (permute, load/store, branch), selects one per cycle by fixed priority, and carries it through a DEPTH-stage staging pipe to the register-file write port. Exposes per-stage forwarding taps for the operand bypass network and flags result-slot collisions.

## Interface
Parameters:
- DEPTH, 4, staging stages from select to writeback (legal 1..8)
- DATA_W, 128, result width (bit 0 = MSB, big-endian numbering)
- ADDR_W, 7, register address width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state when low
- unit_reset  in  1  synchronous pipe flush, active-high
- perm_valid  in  1  permute result valid
- perm_data  in  DATA_W  permute result
- perm_rt  in  ADDR_W  permute destination register
- ls_valid / ls_data / ls_rt  in  1 / DATA_W / ADDR_W  load/store result
- br_valid / br_data / br_rt  in  1 / DATA_W / ADDR_W  branch link result
- wb_we  out  1  register-file write enable
- wb_data  out  DATA_W  writeback data
- wb_rt  out  ADDR_W  writeback register
- wb_unit  out  2  source unit tag of writeback (0 none, 1 perm, 2 ls, 3 br)
- fwd_valid  out  DEPTH  stage i holds a valid result
- fwd_rt  out  DEPTH*ADDR_W  stage i destination, stage 0 in bits [0:ADDR_W-1]
- fwd_data  out  DEPTH*DATA_W  stage i data, same packing
- collision_err  out  1  sticky: two or more units valid in one cycle

## Operation
- Select: priority perm > ls > br. Selected triple plus unit tag loads stage 0 on the edge where any valid is high; otherwise stage 0 valid loads 0 (data/rt retained, don't-care).
- Shift: each edge stage i loads stage i-1, valid included. No stall input; pipe always advances.
- Writeback: wb_we/wb_data/wb_rt/wb_unit are stage DEPTH-1 directly; wb_unit = 0 whenever wb_we = 0.
- Collision: when more than one *_valid is high, lower-priority results are dropped, collision_err sets on that edge and stays set until reset or unit_reset.
- Flush: unit_reset high at an edge clears every stage valid, clears collision_err, and discards any input presented that cycle. Data/rt registers need not clear.
- Reset (low): all valids 0, all data/rt 0, wb_unit 0, collision_err 0; effective immediately, independent of clk.
- Forwarding: consumers must prefer lowest stage index on rt match; block performs no match itself.

## Timing
- Latency: result presented at edge N appears on wb_* after edge N+DEPTH-1, i.e. stage 0 visible on fwd_* immediately after edge N.
- Throughput: one result per cycle, back-to-back with no bubble.
- Reset release: first capture on first rising edge with reset high.
- unit_reset and valid inputs in the same cycle: flush wins.
- DEPTH = 1: stage 0 is the writeback stage; fwd_* and wb_* show the same entry.

## Configuration
- ODD_SEL_COLLISION_CNT_EN defined: adds output coll_cnt [0:7], saturating count of collision cycles (stops at 255), cleared by reset and unit_reset; each collision cycle adds exactly 1 regardless of how many units collided.
- Undefined: port and counter absent; collision_err behaviour unchanged.

## Structure
- Package odd_pipe_pkg: DATA_W, ADDR_W constants, unit tag enum (UNIT_NONE, UNIT_PERM, UNIT_LS, UNIT_BR), stage record type {valid, unit, rt, data}.
- Sub-module odd_pipe_stage: one staging register with valid, flush and async reset; instantiated DEPTH times via generate.
- Priority select and collision detect are combinational in the top level.

## Test plan
- Reset: drive reset low mid-stream with stages full -> all fwd_valid 0, wb_we 0, collision_err 0 without a clock edge.
- Single result: perm_valid=1, perm_rt=7'd5, perm_data=128'hA5..A5 for one cycle, DEPTH=4 -> wb_we=1, wb_rt=5, wb_unit=1 exactly 3 edges later, one cycle wide.
- Back-to-back: perm, ls, br on consecutive cycles with rt 1,2,3 -> wb_rt 1,2,3 on consecutive cycles, wb_unit 1,2,3.
- Collision: perm and ls valid same cycle (rt 4 vs 9) -> only rt 4 written, ls dropped, collision_err=1 and stays; with macro, coll_cnt=1.
- Flush: unit_reset pulse with 3 stages valid and br_valid high -> next cycle fwd_valid all 0, no writeback of any of the four results, collision_err cleared.
- Saturation (macro on): 300 consecutive collision cycles -> coll_cnt = 255.
